// File: rtl/rcs_pkg.sv
// rcs_pkg -- shared types and sizing helpers for the rcs_serial subtractor.
//   rcs_state_t : controller states (IDLE, RUN, DONE)
//   ncyc_f      : number of slice cycles for a WIDTH/CHUNK pair
//   cnt_w_f     : width of the slice counter, never below 1 bit
package rcs_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } rcs_state_t;

  function automatic int ncyc_f(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-slice configuration still needs a 1-bit counter to be legal.
  function automatic int cnt_w_f(input int ncyc);
    return (ncyc > 1) ? $clog2(ncyc) : 1;
  endfunction

endpackage

// File: rtl/rcs_chunk.sv
// rcs_chunk -- combinational CHUNK-bit full-subtractor slice.
// Macro RCS_ADDSUB_EN adds the op input that turns the slice into an adder.
// Ports:
//   a, b : slice operands
//   bin  : borrow-in (carry-in when op=1)
//   op   : 0 subtract, 1 add (only with RCS_ADDSUB_EN)
//   d    : slice result
//   bout : borrow-out (carry-out when op=1)
module rcs_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             bin,
`ifdef RCS_ADDSUB_EN
  input  logic             op,
`endif
  output logic [CHUNK-1:0] d,
  output logic             bout
);

  logic [CHUNK-1:0] b_eff;
  logic             bin_eff;
  logic             inv;
  logic [CHUNK:0]   diff;

`ifdef RCS_ADDSUB_EN
  assign inv = op;
`else
  assign inv = 1'b0;
`endif

  // a + b + c == a - ~b - ~c (mod 2^CHUNK), and the borrow of the right-hand
  // form is the complement of the carry of the left-hand form, so the adder
  // reuses the subtractor by inverting b and both ends of the borrow chain.
  always_comb begin
    b_eff   = inv ? ~b : b;
    bin_eff = inv ? ~bin : bin;
    diff    = {1'b0, a} - {1'b0, b_eff} - {{CHUNK{1'b0}}, bin_eff};
    d       = diff[CHUNK-1:0];
    bout    = inv ? ~diff[CHUNK] : diff[CHUNK];
  end

endmodule

// File: rtl/rcs_serial.sv
// rcs_serial -- multi-cycle ripple-borrow subtractor, d = a - b - bi,
// CHUNK bits per clock over WIDTH bits (NCYC = WIDTH/CHUNK slice cycles).
// Macro RCS_ADDSUB_EN adds op_i: op_i=1 computes d = a + b + bi instead.
// Ports:
//   clk_i, rstn_i            : clock (rising edge), async active-low reset
//   in_valid_i / in_ready_o  : operand handshake
//   a_i, b_i, bi_i           : minuend, subtrahend, borrow-in
//   op_i                     : 0 subtract, 1 add (only with RCS_ADDSUB_EN)
//   out_valid_o / out_ready_i: result handshake
//   d_o, bo_o, ovf_o         : difference, borrow-out, signed overflow
module rcs_serial
  import rcs_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bi_i,
`ifdef RCS_ADDSUB_EN
  input  logic             op_i,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] d_o,
  output logic             bo_o,
  output logic             ovf_o
);

  localparam int NCYC = ncyc_f(WIDTH, CHUNK);
  localparam int CW   = cnt_w_f(NCYC);
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

  // Operands and result viewed as NCYC slices so cnt selects a slice directly.
  typedef logic [NCYC-1:0][CHUNK-1:0] slices_t;

  rcs_state_t       state_q, state_d;
  slices_t          a_q, b_q, res_q, res_nx;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;
  logic             op_q;
  logic             op_in;
  logic             accept;
  logic             last;
  logic [CHUNK-1:0] d_sl;
  logic             bout_sl;
  logic             a_msb, b_msb, d_msb;
  logic             ovf_nx;

`ifdef RCS_ADDSUB_EN
  assign op_in = op_i;
`else
  assign op_in = 1'b0;
`endif

  // Single shared slice, fed by the slice cnt currently points at.
  rcs_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .a    (a_q[cnt_q]),
    .b    (b_q[cnt_q]),
    .bin  (borrow_q),
`ifdef RCS_ADDSUB_EN
    .op   (op_q),
`endif
    .d    (d_sl),
    .bout (bout_sl)
  );

  // Result with the current slice merged in; on the last slice this is the
  // complete answer, so the outputs load from it in the same edge.
  always_comb begin
    res_nx        = res_q;
    res_nx[cnt_q] = d_sl;
  end

  assign a_msb = a_q[NCYC-1][CHUNK-1];
  assign b_msb = b_q[NCYC-1][CHUNK-1];
  assign d_msb = res_nx[NCYC-1][CHUNK-1];

  always_comb begin
    if (op_q) ovf_nx = (a_msb == b_msb) && (d_msb != a_msb);
    else      ovf_nx = (a_msb != b_msb) && (d_msb != a_msb);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    accept      = 1'b0;
    last        = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      op_q     <= 1'b0;
      d_o      <= '0;
      bo_o     <= 1'b0;
      ovf_o    <= 1'b0;
    end else if (accept) begin
      a_q      <= a_i;
      b_q      <= b_i;
      borrow_q <= bi_i;
      cnt_q    <= '0;
      op_q     <= op_in;
    end else if (state_q == RUN) begin
      res_q    <= res_nx;
      borrow_q <= bout_sl;
      cnt_q    <= last ? '0 : cnt_q + 1'b1;
      if (last) begin
        d_o   <= res_nx;
        bo_o  <= bout_sl;
        ovf_o <= ovf_nx;
      end
    end
  end

endmodule

// File: tb/tb_rcs_serial.sv
// tb_rcs_serial -- directed bench for rcs_serial with three instances:
// CHUNK=4 (latency 4), CHUNK=1 (latency 16) and CHUNK=16 (latency 1).
module tb_rcs_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [15:0] a, b;
  logic        bi;
  logic        out_ready;
`ifdef RCS_ADDSUB_EN
  logic        op;
`endif
  logic [2:0]  in_valid, in_ready, out_valid, bo, ovf;
  logic [15:0] d [3];

  int tests = 0;
  int fails = 0;
  int lat;

  logic [15:0] va   [5] = '{16'h1234, 16'h0000, 16'h0000, 16'h8000, 16'h7FFF};
  logic [15:0] vb   [5] = '{16'h0234, 16'h0001, 16'h0000, 16'h0001, 16'hFFFF};
  logic        vbi  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [15:0] ed   [5] = '{16'h1000, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
  logic        ebo  [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  logic        eovf [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  int          elat [3] = '{4, 16, 1};

  rcs_serial #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk_i(clk), .rstn_i(rstn), .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .a_i(a), .b_i(b), .bi_i(bi),
`ifdef RCS_ADDSUB_EN
    .op_i(op),
`endif
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready),
    .d_o(d[0]), .bo_o(bo[0]), .ovf_o(ovf[0])
  );

  rcs_serial #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk_i(clk), .rstn_i(rstn), .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .a_i(a), .b_i(b), .bi_i(bi),
`ifdef RCS_ADDSUB_EN
    .op_i(op),
`endif
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready),
    .d_o(d[1]), .bo_o(bo[1]), .ovf_o(ovf[1])
  );

  rcs_serial #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk_i(clk), .rstn_i(rstn), .in_valid_i(in_valid[2]), .in_ready_o(in_ready[2]),
    .a_i(a), .b_i(b), .bi_i(bi),
`ifdef RCS_ADDSUB_EN
    .op_i(op),
`endif
    .out_valid_o(out_valid[2]), .out_ready_i(out_ready),
    .d_o(d[2]), .bo_o(bo[2]), .ovf_o(ovf[2])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction on instance sel with an always-ready consumer.
  task automatic run(input int sel, input logic [15:0] av, input logic [15:0] bv,
                     input logic biv, input logic [15:0] exd, input logic exbo,
                     input logic exovf, input int exlat, input string tag);
    int n = 0;
    @(negedge clk);
    a = av; b = bv; bi = biv; in_valid[sel] = 1'b1; out_ready = 1'b1;
    check({tag, "_inrdy"}, {31'd0, in_ready[sel]}, 32'd1);
    @(posedge clk); #1;
    in_valid[sel] = 1'b0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_valid[sel] && n < 40);
    check({tag, "_lat"}, n, exlat);
    check({tag, "_d"}, {16'd0, d[sel]}, {16'd0, exd});
    check({tag, "_bo"}, {31'd0, bo[sel]}, {31'd0, exbo});
    check({tag, "_ovf"}, {31'd0, ovf[sel]}, {31'd0, exovf});
    @(posedge clk); #1;
    check({tag, "_vld_drop"}, {31'd0, out_valid[sel]}, 32'd0);
    check({tag, "_d_hold"}, {16'd0, d[sel]}, {16'd0, exd});
  endtask

  initial begin
    rstn = 1'b0; a = '0; b = '0; bi = 1'b0; in_valid = '0; out_ready = 1'b0;
`ifdef RCS_ADDSUB_EN
    op = 1'b0;
`endif
    #12;
    for (int s = 0; s < 3; s++) begin
      check($sformatf("rst%0d_inrdy", s), {31'd0, in_ready[s]}, 32'd1);
      check($sformatf("rst%0d_vld", s), {31'd0, out_valid[s]}, 32'd0);
      check($sformatf("rst%0d_d", s), {16'd0, d[s]}, 32'd0);
      check($sformatf("rst%0d_bo", s), {31'd0, bo[s]}, 32'd0);
      check($sformatf("rst%0d_ovf", s), {31'd0, ovf[s]}, 32'd0);
    end
    @(negedge clk);
    rstn = 1'b1;

    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 5; i++)
        run(s, va[i], vb[i], vbi[i], ed[i], ebo[i], eovf[i], elat[s],
            $sformatf("s%0d_v%0d", s, i));

    run(0, 16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0, 4, "mix");

    // Backpressure: consumer stalls while new operands are offered.
    @(negedge clk);
    a = 16'h00F0; b = 16'h000F; bi = 1'b0; in_valid[0] = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid[0] && lat < 40);
    check("bp_lat", lat, 4);
    check("bp_d", {16'd0, d[0]}, 32'h00E1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      a = 16'hFFFF; b = 16'h0000; in_valid[0] = 1'b1;
      @(posedge clk); #1;
      check($sformatf("bp%0d_vld", k), {31'd0, out_valid[0]}, 32'd1);
      check($sformatf("bp%0d_d", k), {16'd0, d[0]}, 32'h00E1);
      check($sformatf("bp%0d_inrdy", k), {31'd0, in_ready[0]}, 32'd0);
    end
    @(negedge clk);
    in_valid[0] = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_rel_vld", {31'd0, out_valid[0]}, 32'd0);
    check("bp_rel_inrdy", {31'd0, in_ready[0]}, 32'd1);
    check("bp_rel_d", {16'd0, d[0]}, 32'h00E1);
    run(0, 16'h0010, 16'h0001, 1'b0, 16'h000F, 1'b0, 1'b0, 4, "bp_next");

    // Reset two cycles into RUN.
    @(negedge clk);
    a = 16'h1234; b = 16'h0234; bi = 1'b0; in_valid[0] = 1'b1;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check("mid_rst_inrdy", {31'd0, in_ready[0]}, 32'd1);
    check("mid_rst_vld", {31'd0, out_valid[0]}, 32'd0);
    check("mid_rst_d", {16'd0, d[0]}, 32'd0);
    check("mid_rst_bo", {31'd0, bo[0]}, 32'd0);
    check("mid_rst_ovf", {31'd0, ovf[0]}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    run(0, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 4, "post_rst");

`ifdef RCS_ADDSUB_EN
    op = 1'b1;
    for (int s = 0; s < 3; s++)
      run(s, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, elat[s],
          $sformatf("add%0d", s));
    run(0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 4, "add_ovf");
    op = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
